cu_ram_sync: RTL and testbench

- Parametrised successor to the control-unit data RAM, sitting between the control unit and the data store.
- Fully synchronous, posedge-only single-port RAM with a valid/ready request interface.
- Read responses are registered and flagged with a valid pulse.
- A hardware clear engine zeroes the array one word per cycle, after reset or on demand, while flagging busy.
- Out-of-range addresses are detected and reported.

---
 rtl/cu_ram_sync.sv | 78 +++++++
 tb/tb_cu_ram_sync.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cu_ram_sync.sv
// cu_ram_sync: single-port synchronous RAM with valid/ready requests, registered reads and a clear engine
module cu_ram_sync #(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 8,
  parameter int DEPTH          = 256,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              err_oob,
  input  logic              clear_start,
  output logic              busy
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST    = (ADDR_W+1)'(DEPTH - 1);
  typedef enum logic {S_CLEAR, S_READY} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              rsp_valid_q, rsp_valid_d, err_oob_q, err_oob_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              accept, oob, rd, wr_en, clr_en;
  logic [IW-1:0]     idx;
  assign accept    = req_valid && req_ready;
  assign oob       = {1'b0, req_addr} >= DEPTH_W;
  assign rd        = accept && !req_write;
  assign idx       = req_addr[IW-1:0];
  assign wr_en     = reset && accept && req_write && !oob;
  assign clr_en    = reset && state_q == S_CLEAR;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign err_oob   = err_oob_q;
  // Clear walks the pointer to the last word, then hands control back to requests
  always_comb begin
    state_d = state_q == S_CLEAR ? (ptr_q == LAST ? S_READY : S_CLEAR) : (clear_start ? S_CLEAR : S_READY);
    ptr_d   = state_q == S_CLEAR && ptr_q != LAST ? ptr_q + (ADDR_W+1)'(1) : '0;
  end
  // Handshake and busy are pure decodes of the registered state
  always_comb begin
    req_ready = state_q == S_READY;
    busy      = state_q == S_CLEAR;
  end
  // Read response: out-of-range reads answer zero; idle cycles keep the last data
  always_comb begin
    rsp_valid_d = rd;
    err_oob_d   = accept && oob;
    rsp_rdata_d = rd ? (oob ? '0 : mem_q[idx]) : rsp_rdata_q;
  end
  // State, clear pointer and response registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= CLEAR_ON_RESET != 0 ? S_CLEAR : S_READY;
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      err_oob_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      err_oob_q   <= err_oob_d;
    end
  end
  // Storage array: request writes in READY, zero fill one word per cycle in CLEAR
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[idx] <= req_wdata;
    else if (clr_en) mem_q[ptr_q[IW-1:0]] <= '0;
  end
endmodule

// File: tb/tb_cu_ram_sync.sv
// tb_cu_ram_sync: scoreboard bench for cu_ram_sync across default, DEPTH=200 and no-clear-on-reset builds
module tb_cu_ram_sync;
  typedef struct {
    int         inst;
    int         cyc;
    logic       rd;
    logic       oob;
    logic [7:0] a;
    logic [7:0] d;
  } exp_t;
  logic       clk = 1'b0;
  logic [2:0] rst, valid, clr, ready, rsp_valid, err_oob, busy;
  logic       req_write;
  logic [7:0] req_addr, req_wdata;
  logic [7:0] rdata [3];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  exp_t       q[$];
  exp_t       mon_e;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  cu_ram_sync u0 (
    .clk(clk), .reset(rst[0]), .req_valid(valid[0]), .req_ready(ready[0]), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid[0]), .rsp_rdata(rdata[0]),
    .err_oob(err_oob[0]), .clear_start(clr[0]), .busy(busy[0])
  );
  cu_ram_sync #(.DEPTH(200)) u1 (
    .clk(clk), .reset(rst[1]), .req_valid(valid[1]), .req_ready(ready[1]), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid[1]), .rsp_rdata(rdata[1]),
    .err_oob(err_oob[1]), .clear_start(clr[1]), .busy(busy[1])
  );
  cu_ram_sync #(.CLEAR_ON_RESET(0)) u2 (
    .clk(clk), .reset(rst[2]), .req_valid(valid[2]), .req_ready(ready[2]), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid[2]), .rsp_rdata(rdata[2]),
    .err_oob(err_oob[2]), .clear_start(clr[2]), .busy(busy[2])
  );
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].cyc < cyc) begin
      errors++;
      $display("FAIL missing_rsp inst%0d addr %h: no response at cycle %0d", q[0].inst, q[0].a, q[0].cyc);
      void'(q.pop_front());
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (q.size() > 0 && q[0].inst == i && q[0].cyc == cyc) begin
        mon_e = q.pop_front();
        if (rsp_valid[i] !== mon_e.rd || err_oob[i] !== mon_e.oob || (mon_e.rd && rdata[i] !== mon_e.d)) begin
          errors++;
          $display("FAIL rsp inst%0d addr %h: got valid=%b oob=%b data=%h, want valid=%b oob=%b data=%h",
                   i, mon_e.a, rsp_valid[i], err_oob[i], rdata[i], mon_e.rd, mon_e.oob, mon_e.d);
        end
      end else if (rsp_valid[i] !== 1'b0 || err_oob[i] !== 1'b0) begin
        errors++;
        $display("FAIL spurious inst%0d cycle %0d: got valid=%b oob=%b, want 0 0", i, cyc, rsp_valid[i], err_oob[i]);
      end
    end
  end
  task automatic issue(input int i, input logic w, input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] e, input logic oob, input logic cs);
    valid[i]  = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    clr[i]    = cs;
    if (!w || oob) q.push_back('{i, cyc + 1, !w, oob, a, e});
    @(posedge clk);
    #1;
    valid[i] = 1'b0;
    clr[i]   = 1'b0;
  endtask
  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rsp_valid[i] !== 1'b0 || err_oob[i] !== 1'b0 || rdata[i] !== 8'h00) begin
        errors++;
        $display("FAIL reset_outputs inst%0d: got v=%b oob=%b d=%h, want 0 0 00", i, rsp_valid[i], err_oob[i], rdata[i]);
      end
    end
    checks++;
    if (busy !== 3'b011 || ready !== 3'b100) begin
      errors++;
      $display("FAIL reset_state: got busy=%b ready=%b, want busy=011 ready=100", busy, ready);
    end
    rst = 3'b111;
  endtask
  task automatic test_clear_after_reset;
    int n = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (!busy[0]) break;
      checks++;
      if (ready[0] !== 1'b0) begin
        errors++;
        $display("FAIL ready_in_clear: got %b, want 0", ready[0]);
      end
      n++;
    end
    checks++;
    if (n != 256) begin
      errors++;
      $display("FAIL reset_clear_len: got %0d cycles, want 256", n);
    end
    @(posedge clk);
    #1;
    checks++;
    if (ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_clear: got %b, want 1", ready[0]);
    end
    issue(0, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    issue(0, 0, 8'h7F, 8'h00, 8'h00, 0, 0);
    issue(0, 0, 8'hFF, 8'h00, 8'h00, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_t1: got %0d pending, want 0", q.size());
    end
  endtask
  task automatic test_back_to_back;
    issue(0, 1, 8'h10, 8'hA5, 8'h00, 0, 0);
    issue(0, 0, 8'h10, 8'h00, 8'hA5, 0, 0);
    issue(0, 0, 8'h10, 8'h00, 8'hA5, 0, 0);
    issue(0, 0, 8'h11, 8'h00, 8'h00, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    issue(0, 0, 8'h10, 8'h00, 8'hA5, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rsp_valid[0] !== 1'b0 || rdata[0] !== 8'hA5 || q.size() != 0) begin
      errors++;
      $display("FAIL rdata_hold: got v=%b d=%h pending=%0d, want 0 a5 0", rsp_valid[0], rdata[0], q.size());
    end
  endtask
  task automatic test_oob;
    checks++;
    if (ready[1] !== 1'b1) begin
      errors++;
      $display("FAIL ready_d200: got %b, want 1", ready[1]);
    end
    issue(1, 1, 8'hC7, 8'h5A, 8'h00, 0, 0);
    issue(1, 1, 8'hC8, 8'h55, 8'h00, 1, 0);
    issue(1, 0, 8'hC8, 8'h00, 8'h00, 1, 0);
    issue(1, 0, 8'hFF, 8'h00, 8'h00, 1, 0);
    issue(1, 0, 8'hC7, 8'h00, 8'h5A, 0, 0);
    for (int a = 0; a < 199; a++) issue(1, 0, 8'(a), 8'h00, 8'h00, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_oob: got %0d pending, want 0", q.size());
    end
  endtask
  task automatic test_clear_start;
    int n = 0;
    for (int a = 0; a < 256; a++) issue(0, 1, 8'(a), 8'h3C, 8'h00, 0, 0);
    issue(0, 0, 8'h05, 8'h00, 8'h3C, 0, 1);
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (!busy[0]) break;
      n++;
      clr[0] = (n == 100);
    end
    clr[0] = 1'b0;
    checks++;
    if (n != 256) begin
      errors++;
      $display("FAIL clear_start_len: got %0d cycles, want 256", n);
    end
    @(posedge clk);
    #1;
    issue(0, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    issue(0, 0, 8'h05, 8'h00, 8'h00, 0, 0);
    issue(0, 0, 8'h80, 8'h00, 8'h00, 0, 0);
    issue(0, 0, 8'hFF, 8'h00, 8'h00, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_clear: got %0d pending, want 0", q.size());
    end
  endtask
  task automatic test_reset_mid_clear;
    int n = 0;
    issue(0, 1, 8'hF0, 8'h99, 8'h00, 0, 1);
    repeat (100) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy[0] !== 1'b1 || ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_clear_reset: got busy=%b ready=%b, want 1 0", busy[0], ready[0]);
    end
    rst[0] = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (!busy[0]) break;
      n++;
    end
    checks++;
    if (n != 256) begin
      errors++;
      $display("FAIL restart_clear_len: got %0d cycles, want 256", n);
    end
    @(posedge clk);
    #1;
    issue(0, 0, 8'hF0, 8'h00, 8'h00, 0, 0);
    issue(0, 0, 8'h7F, 8'h00, 8'h00, 0, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask
  task automatic test_no_clear_on_reset;
    issue(2, 1, 8'h20, 8'h77, 8'h00, 0, 0);
    rst[2] = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (busy[2] !== 1'b0 || ready[2] !== 1'b1) begin
      errors++;
      $display("FAIL nocor_reset: got busy=%b ready=%b, want 0 1", busy[2], ready[2]);
    end
    rst[2] = 1'b1;
    issue(2, 0, 8'h20, 8'h00, 8'h77, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy[2] !== 1'b0 || q.size() != 0) begin
      errors++;
      $display("FAIL nocor_end: got busy=%b pending=%0d, want 0 0", busy[2], q.size());
    end
  endtask
  initial begin
    rst = 3'b000;
    valid = 3'b000;
    clr = 3'b000;
    req_write = 1'b0;
    req_addr = 8'h00;
    req_wdata = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    test_clear_after_reset;
    test_back_to_back;
    test_oob;
    test_clear_start;
    test_reset_mid_clear;
    test_no_clear_on_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
